// File: rtl/vs_reader_pkg.sv
// Shared types and constants for the result-word reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vs_reader_pkg;

    localparam int COUNT_W = 16;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == COUNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vs_sync_fifo.sv
// Generic synchronous FIFO with a registered pop port.
// Latency: pushed word is poppable the next cycle; popped word appears 1 cycle after pop.
// Backpressure: push ignored while full, pop ignored while empty; caller gates on full/empty.
module vs_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4     // power of two, at least 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells a full buffer from an empty one after wrap.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance; reset discards every buffered entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Registered read port: data holds between pops, valid pulses per pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/vs_word_reader.sv
// Collects result words from a generated FSM into a FIFO, counts them and stops after MAX_WORDS.
// Latency: accepted word readable the cycle after the handshake; rd_data 1 cycle after rd_en.
// Backpressure: in_ready low in INIT, DONE or when the FIFO is full; never depends on in_valid.
module vs_word_reader
    import vs_reader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int MAX_WORDS   = 8,
    parameter int CHANGE_ONLY = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               rd_en,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               empty,
    output logic               full,
    output logic [COUNT_W-1:0] word_count,
    output logic               done
);

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_WORDS);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] last_word;
    logic              have_last;
    logic              handshake;
    logic              is_new;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;

    // A handshake always consumes the word; only a new value is stored and counted.
    assign handshake = in_valid && in_ready;
    assign is_new    = (CHANGE_ONLY == 0) || !have_last || (in_data != last_word);
    assign accept    = handshake && is_new;

    assign full  = fifo_full;
    assign empty = fifo_empty;

    // State register; reset drops straight back to INIT so in_ready falls at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake-side outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            ST_INIT: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                in_ready = !fifo_full;
                if (accept && (sat_inc(word_count) == MAX_CNT)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Accepted-word counter and the last-value memory used by the change filter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count <= '0;
            last_word  <= '0;
            have_last  <= 1'b0;
        end else if (accept) begin
            word_count <= sat_inc(word_count);
            last_word  <= in_data;
            have_last  <= 1'b1;
        end
    end

    vs_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (in_data),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_vs_word_reader.sv
module tb_vs_word_reader;

    localparam int DEPTH = 4;
    localparam int MAX_A = 8;
    localparam int CO_A  = 0;
    localparam int MAX_B = 16;
    localparam int CO_B  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: CHANGE_ONLY=0, MAX_WORDS=8
    logic        a_rst;
    logic [31:0] a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic        a_rd_en;
    logic [31:0] a_rd_data;
    logic        a_rd_valid;
    logic        a_empty;
    logic        a_full;
    logic [15:0] a_word_count;
    logic        a_done;

    // Instance B: CHANGE_ONLY=1, MAX_WORDS=16
    logic        b_rst;
    logic [31:0] b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic        b_rd_en;
    logic [31:0] b_rd_data;
    logic        b_rd_valid;
    logic        b_empty;
    logic        b_full;
    logic [15:0] b_word_count;
    logic        b_done;

    vs_word_reader #(.DATA_W(32), .DEPTH(DEPTH), .MAX_WORDS(MAX_A), .CHANGE_ONLY(CO_A)) dut_a (
        .clk(clk), .reset(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .empty(a_empty), .full(a_full), .word_count(a_word_count), .done(a_done)
    );

    vs_word_reader #(.DATA_W(32), .DEPTH(DEPTH), .MAX_WORDS(MAX_B), .CHANGE_ONLY(CO_B)) dut_b (
        .clk(clk), .reset(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .empty(b_empty), .full(b_full), .word_count(b_word_count), .done(b_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: phase 0=init 1=run 2=done ----------------
    logic [31:0] qa[$];
    int          ph_a = 0;
    int          cnt_a = 0;
    logic [31:0] last_a = 0;
    bit          have_a = 0;
    logic [31:0] mrd_a = 0;
    bit          mrv_a = 0;

    logic [31:0] qb[$];
    int          ph_b = 0;
    int          cnt_b = 0;
    logic [31:0] last_b = 0;
    bit          have_b = 0;
    logic [31:0] mrd_b = 0;
    bit          mrv_b = 0;

    always @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            qa.delete(); ph_a = 0; cnt_a = 0; last_a = 0; have_a = 0; mrd_a = 0; mrv_a = 0;
        end else begin
            bit rdy;
            bit take;
            rdy  = (ph_a == 1) && (qa.size() < DEPTH);
            take = a_rd_en && (qa.size() > 0);
            mrv_a = take;
            if (take) mrd_a = qa.pop_front();
            if (a_in_valid && rdy && (CO_A == 0 || !have_a || a_in_data != last_a)) begin
                qa.push_back(a_in_data);
                if (cnt_a < 65535) cnt_a++;
                last_a = a_in_data;
                have_a = 1;
                if (cnt_a == MAX_A) ph_a = 2;
            end
            if (ph_a == 0) ph_a = 1;
        end
    end

    always @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            qb.delete(); ph_b = 0; cnt_b = 0; last_b = 0; have_b = 0; mrd_b = 0; mrv_b = 0;
        end else begin
            bit rdy;
            bit take;
            rdy  = (ph_b == 1) && (qb.size() < DEPTH);
            take = b_rd_en && (qb.size() > 0);
            mrv_b = take;
            if (take) mrd_b = qb.pop_front();
            if (b_in_valid && rdy && (CO_B == 0 || !have_b || b_in_data != last_b)) begin
                qb.push_back(b_in_data);
                if (cnt_b < 65535) cnt_b++;
                last_b = b_in_data;
                have_b = 1;
                if (cnt_b == MAX_B) ph_b = 2;
            end
            if (ph_b == 0) ph_b = 1;
        end
    end

    // Compare every output of both instances against the model, away from the active edge.
    always @(negedge clk) begin
        chk("a_in_ready",   a_in_ready,   (ph_a == 1) && (qa.size() < DEPTH));
        chk("a_rd_valid",   a_rd_valid,   mrv_a);
        chk("a_rd_data",    a_rd_data,    mrd_a);
        chk("a_empty",      a_empty,      qa.size() == 0);
        chk("a_full",       a_full,       qa.size() == DEPTH);
        chk("a_word_count", a_word_count, cnt_a);
        chk("a_done",       a_done,       ph_a == 2);
        chk("b_in_ready",   b_in_ready,   (ph_b == 1) && (qb.size() < DEPTH));
        chk("b_rd_valid",   b_rd_valid,   mrv_b);
        chk("b_rd_data",    b_rd_data,    mrd_b);
        chk("b_empty",      b_empty,      qb.size() == 0);
        chk("b_full",       b_full,       qb.size() == DEPTH);
        chk("b_word_count", b_word_count, cnt_b);
        chk("b_done",       b_done,       ph_b == 2);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    logic [31:0] got[$];

    initial begin
        a_rst = 1'b1; a_in_data = 0; a_in_valid = 0; a_rd_en = 0;
        b_rst = 1'b1; b_in_data = 0; b_in_valid = 0; b_rd_en = 0;
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_empty",    a_empty, 1);
        chk("rst_count",    a_word_count, 0);
        chk("rst_done",     a_done, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_rd_data",  a_rd_data, 0);

        // Held word 123, CHANGE_ONLY=0: INIT cycle, then one accept per cycle up to 8
        a_in_valid = 1; a_in_data = 123; a_rd_en = 1; a_rst = 1'b1;
        chk("t1_init_ready", a_in_ready, 0);
        step();
        chk("t1_run_ready", a_in_ready, 1);
        chk("t1_count0", a_word_count, 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t1_count", a_word_count, i);
        end
        chk("t1_done", a_done, 1);
        chk("t1_ready_in_done", a_in_ready, 0);
        step();
        chk("t1_count_hold", a_word_count, 8);
        chk("t1_done_hold", a_done, 1);
        a_in_valid = 0; a_rd_en = 0;

        // Fill to full with 1..4, then one pop
        a_rst = 1'b0; step(); a_rst = 1'b1; step();
        for (int i = 1; i <= 4; i++) begin
            a_in_data = i; a_in_valid = 1;
            step();
        end
        a_in_valid = 0;
        chk("t3_full", a_full, 1);
        chk("t3_ready_full", a_in_ready, 0);
        chk("t3_count", a_word_count, 4);
        a_rd_en = 1;
        step();
        a_rd_en = 0;
        chk("t3_rd_valid", a_rd_valid, 1);
        chk("t3_rd_data", a_rd_data, 1);
        chk("t3_ready_after_pop", a_in_ready, 1);
        chk("t3_not_full", a_full, 0);

        // Drain the rest, then read while empty
        a_rd_en = 1;
        step(); step(); step();
        chk("t5_last_data", a_rd_data, 4);
        chk("t5_last_valid", a_rd_valid, 1);
        step();
        chk("t5_empty_rd_valid", a_rd_valid, 0);
        chk("t5_empty_rd_data", a_rd_data, 4);
        chk("t5_empty", a_empty, 1);
        a_rd_en = 0;
        step();
        chk("t5_idle_rd_valid", a_rd_valid, 0);
        chk("t5_idle_rd_data", a_rd_data, 4);

        // Reset with 3 words buffered and a word in flight
        a_rst = 1'b0; step(); a_rst = 1'b1; step();
        for (int i = 7; i <= 9; i++) begin
            a_in_data = i; a_in_valid = 1;
            step();
        end
        a_in_data = 10;
        chk("t6_count_before", a_word_count, 3);
        chk("t6_not_empty", a_empty, 0);
        a_rst = 1'b0;
        #1;
        chk("t6_rst_empty", a_empty, 1);
        chk("t6_rst_count", a_word_count, 0);
        chk("t6_rst_done", a_done, 0);
        chk("t6_rst_ready", a_in_ready, 0);
        step();
        a_rst = 1'b1;
        chk("t6_init_ready", a_in_ready, 0);
        step();
        chk("t6_run_ready", a_in_ready, 1);
        step();
        a_in_valid = 0;
        chk("t6_resume_count", a_word_count, 1);
        a_rd_en = 1;
        step();
        a_rd_en = 0;
        chk("t6_resume_data", a_rd_data, 10);
        chk("t6_resume_valid", a_rd_valid, 1);

        // CHANGE_ONLY=1: 123 held, then 456
        b_in_valid = 1; b_in_data = 123; b_rst = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        b_in_data = 456;
        step();
        b_in_valid = 0;
        chk("t2_count", b_word_count, 2);
        b_rd_en = 1;
        step();
        b_rd_en = 0;
        chk("t2_pop1_valid", b_rd_valid, 1);
        chk("t2_pop1_data", b_rd_data, 123);
        step();
        chk("t2_gap_valid", b_rd_valid, 0);
        chk("t2_gap_data", b_rd_data, 123);
        b_rd_en = 1;
        step();
        b_rd_en = 0;
        chk("t2_pop2_valid", b_rd_valid, 1);
        chk("t2_pop2_data", b_rd_data, 456);
        chk("t2_empty", b_empty, 1);

        // Continuous push and pop of 1..12 through a 4-deep FIFO
        b_rst = 1'b0; step(); b_rst = 1'b1; step();
        b_rd_en = 1;
        for (int i = 1; i <= 12; i++) begin
            b_in_data = i; b_in_valid = 1;
            step();
            if (b_rd_valid) got.push_back(b_rd_data);
        end
        b_in_valid = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (b_rd_valid) got.push_back(b_rd_data);
        end
        b_rd_en = 0;
        chk("t4_n_words", got.size(), 12);
        for (int k = 0; k < got.size(); k++) chk("t4_order", got[k], k + 1);
        chk("t4_empty", b_empty, 1);
        chk("t4_count", b_word_count, 12);
        chk("t4_not_done", b_done, 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vs_word_reader.md
Name: vs_word_reader

Overview:
- Consumer end of the 32-bit result-word interface driven by VSharp-generated FSM modules.
- A generated module presents a word with a valid/ready handshake; this block accepts it into a small FIFO and counts accepted words.
- The host or testbench drains the FIFO through a registered read port.
- After a programmed number of words, the block stops accepting and signals done. Test harnesses use it to collect generated-module outputs deterministically.

Parameters:
- DATA_W, 32, width of each result word.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- MAX_WORDS, 8, number of accepted words after which the block enters DONE.
- CHANGE_ONLY, 0, when 1, accept only words whose value differs from the last accepted word; repeats are consumed and discarded.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  word from the producer.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block will accept the word this cycle.
- rd_en  in  1  host pops one word.
- rd_data  out  DATA_W  popped word, registered.
- rd_valid  out  1  rd_data holds a word popped on the previous cycle.
- empty  out  1  FIFO holds zero entries.
- full  out  1  FIFO holds DEPTH entries.
- word_count  out  16  number of words accepted since reset; saturates at 16'hFFFF.
- done  out  1  MAX_WORDS words have been accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=INIT, FIFO pointers=0, word_count=0, rd_data=0, rd_valid=0, done=0, last-word register=0, have_last=0.
- States:
  - INIT: held for exactly one cycle after reset release with in_ready=0, then moves to RUN.
  - RUN: in_ready = !full. A handshake occurs when in_valid && in_ready at a rising edge.
  - DONE: in_ready=0 and done=1. The block leaves DONE only through reset.
- Handshake in RUN:
  - If CHANGE_ONLY=0, or have_last=0, or in_data != last word: write in_data to the FIFO, increment word_count, set last=in_data and have_last=1.
  - Otherwise (repeat under CHANGE_ONLY=1): the word is consumed with no write and no count.
- RUN to DONE: on the edge where word_count becomes MAX_WORDS. done asserts the following cycle; in_ready is 0 from that cycle onward.
- Read port:
  - rd_en && !empty pops the head into rd_data and sets rd_valid=1 on the next cycle (latency 1).
  - rd_en while empty: no pop, rd_valid=0, rd_data holds its value.
  - A cycle without a valid pop drives rd_valid=0 and rd_data holds.
- Simultaneous push and pop:
  - When not full and not empty, both occur and the occupancy is unchanged.
  - When full: in_ready is already 0 that cycle, so only the pop occurs; in_ready rises the next cycle.
  - When empty: only the push occurs. There is no fall-through; the word is readable from the next cycle.
- Popping continues in DONE and in INIT (FIFO is empty in INIT).
- Pointers are log2(DEPTH)+1 bits wide; the extra bit disambiguates full from empty on wrap-around.
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal and the MSBs differ.
- in_ready is combinational from state and full. It never depends on in_valid.
- Reset asserted mid-transfer discards all FIFO contents and any in-flight word; in_ready falls immediately (asynchronously).

Decomposition:
- Package vs_reader_pkg: state enum (ST_INIT, ST_RUN, ST_DONE) and the COUNT_W=16 constant.
- One sub-module vs_sync_fifo (parameters DATA_W, DEPTH) containing the storage array, pointers, full/empty logic and registered pop.
- The top level holds the FSM, change filter, counter and done logic.

Test Plan:
- Reset release, in_valid=1, in_data=32'd123 held → in_ready=0 in the first cycle (INIT), then the word is accepted. With CHANGE_ONLY=0, word_count increments every cycle until 8, then done=1 and in_ready=0.
- CHANGE_ONLY=1, in_data held at 32'd123 for 10 cycles, then 32'd456 → word_count=2; pops return 123 then 456 with rd_valid one cycle after each rd_en.
- Push 4 words 1,2,3,4 with no reads → full=1, in_ready=0; a single rd_en yields rd_data=1 and in_ready=1 the next cycle.
- Continuous push and pop with DEPTH=4 for 12 words (MAX_WORDS=16) → data returns in order 1..12, covering pointer wrap; empty=1 at the end.
- rd_en while empty → rd_valid=0 and rd_data unchanged.
- Assert reset with 3 words buffered and word_count=3 → empty=1, word_count=0, done=0, in_ready=0 immediately; normal operation resumes after the INIT cycle.
